// File: rtl/button_pio_debounce.sv
// Debounced button PIO with an Avalon-MM slave.
// Synchroniser, per-channel debounce, edge capture and masked irq.
module button_pio_debounce #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SYNC_STAGES     = 2,
  parameter int IDLE_LEVEL      = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  localparam logic [CW-1:0] CNT_MAX =
    CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [WIDTH-1:0] IDLE_VEC =
    (IDLE_LEVEL != 0) ? {WIDTH{1'b1}}
                      : {WIDTH{1'b0}};

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_d;
  logic [WIDTH-1:0][CW-1:0]          cnt_q;
  logic [WIDTH-1:0][CW-1:0]          cnt_d;
  logic [WIDTH-1:0]                  stable_q;
  logic [WIDTH-1:0]                  stable_d;
  logic [WIDTH-1:0]                  mask_q;
  logic [WIDTH-1:0]                  mask_d;
  logic [WIDTH-1:0]                  cap_q;
  logic [WIDTH-1:0]                  cap_d;
  logic [WIDTH-1:0]                  mode_q;
  logic [WIDTH-1:0]                  mode_d;
  logic [31:0]                       rd_q;
  logic [31:0]                       rd_d;

  logic [WIDTH-1:0] synced;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] set_v;
  logic [WIDTH-1:0] clr_v;
  logic [WIDTH-1:0] wd;
  logic             wr;
  logic             unused_wd;

  assign unused_wd = ^writedata;

  // Shift raw inputs through the synchroniser chain.
  always_comb begin
    sync_d = sync_q;
    sync_d[0] = in_port;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

  // Per-channel persistence counter and stable bit.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (synced[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        stable_d[i] = synced[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  assign rise  = stable_d & ~stable_q;
  assign fall  = ~stable_d & stable_q;
  assign set_v = (rise & mode_q) | (fall & ~mode_q);
  assign wr    = chipselect & ~write_n;
  assign wd    = writedata[WIDTH-1:0];

  // Register writes; a capture set beats a same-cycle clear.
  always_comb begin
    mask_d = mask_q;
    mode_d = mode_q;
    clr_v  = '0;
    if (wr) begin
      unique case (address)
        2'd1:    mask_d = wd;
        2'd2:    clr_v  = wd;
        2'd3:    mode_d = wd;
        default: ;
      endcase
    end
    cap_d = (cap_q & ~clr_v) | set_v;
  end

  // Read mux, registered every cycle.
  always_comb begin
    rd_d = '0;
    unique case (address)
      2'd0:    rd_d = 32'(stable_q);
      2'd1:    rd_d = 32'(mask_q);
      2'd2:    rd_d = 32'(cap_q);
      default: rd_d = 32'(mode_q);
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= {SYNC_STAGES{IDLE_VEC}};
      stable_q <= IDLE_VEC;
      cnt_q    <= '0;
      mask_q   <= '0;
      cap_q    <= '0;
      mode_q   <= '0;
      rd_q     <= '0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      cap_q    <= cap_d;
      mode_q   <= mode_d;
      rd_q     <= rd_d;
    end
  end

  assign readdata = rd_q;
  assign irq      = |(cap_q & mask_q);

endmodule
